// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master) and data memory.
interface mem_access_stage_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) ();
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: bypasses ALU results or runs one load/store per instruction on dmem,
// stalling upstream while busy. Optional access timeout built when MEM_TIMEOUT_EN is defined.
module mem_access_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned WA_W   = 5
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 64
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               mem_bypass_in,
   input  logic               mem_we_in,
   input  logic               mux_in,
   input  logic [DATA_W-1:0]  rd2_in,
   input  logic [DATA_W-1:0]  alu_in,
   input  logic [WA_W-1:0]    wa_in,
   output logic               stall_out,
   mem_access_stage_if.master dmem,
   output logic               wb_valid,
   output logic               wb_we,
   output logic [WA_W-1:0]    wb_wa,
   output logic [DATA_W-1:0]  wb_data,
   output logic               mem_err
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e            state;
   logic [DATA_W-1:0] alu_c;
   logic              mux_c;
   logic              we_c;
   logic [WA_W-1:0]   wa_c;
`ifdef MEM_TIMEOUT_EN
   logic [7:0]        cnt;
`endif

   assign stall_out = (state == StBusy);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         alu_c      <= '0;
         mux_c      <= 1'b0;
         we_c       <= 1'b0;
         wa_c       <= '0;
         dmem.req   <= 1'b0;
         dmem.we    <= 1'b0;
         dmem.addr  <= '0;
         dmem.wdata <= '0;
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_wa      <= '0;
         wb_data    <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt        <= '0;
         mem_err    <= 1'b0;
`endif
      end else begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         mem_err  <= 1'b0;
`endif
         case (state)
            StIdle: begin
               // mux_in is ignored on bypass: an illegal bypass+mux still writes back alu_in
               if (in_valid && mem_bypass_in) begin
                  wb_valid <= 1'b1;
                  wb_we    <= (wa_in != '0);
                  wb_wa    <= wa_in;
                  wb_data  <= alu_in;
               end else if (in_valid) begin
                  state      <= StBusy;
                  alu_c      <= alu_in;
                  mux_c      <= mux_in;
                  we_c       <= mem_we_in;
                  wa_c       <= wa_in;
                  dmem.req   <= 1'b1;
                  dmem.we    <= mem_we_in;
                  dmem.addr  <= alu_in[ADDR_W-1:0];
                  dmem.wdata <= rd2_in;
`ifdef MEM_TIMEOUT_EN
                  cnt        <= '0;
`endif
               end
            end
            StBusy: begin
               if (dmem.ack) begin
                  state    <= StIdle;
                  dmem.req <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_wa    <= wa_c;
                  if (we_c) begin
                     wb_we   <= 1'b0;
                     wb_data <= '0;
                  end else begin
                     wb_we   <= (wa_c != '0);
                     wb_data <= mux_c ? dmem.rdata : alu_c;
                  end
`ifdef MEM_TIMEOUT_EN
               end else if (cnt == 8'(TIMEOUT - 1)) begin
                  // Abort: retire the instruction without a register write and flag it
                  state    <= StIdle;
                  dmem.req <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_wa    <= wa_c;
                  wb_data  <= '0;
                  mem_err  <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
`endif
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifndef MEM_TIMEOUT_EN
   assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven bench for mem_access_stage with a writeback scoreboard and a bench-side memory.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, mem_bypass_in, mem_we_in, mux_in;
   logic [15:0] rd2_in, alu_in;
   logic [4:0]  wa_in;
   logic        stall_out, wb_valid, wb_we, mem_err;
   logic [4:0]  wb_wa;
   logic [15:0] wb_data;

   mem_access_stage_if #(.ADDR_W(16), .DATA_W(16)) dmem ();

`ifdef MEM_TIMEOUT_EN
   mem_access_stage #(.DATA_W(16), .ADDR_W(16), .WA_W(5), .TIMEOUT(4)) dut (
`else
   mem_access_stage #(.DATA_W(16), .ADDR_W(16), .WA_W(5)) dut (
`endif
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .mem_bypass_in(mem_bypass_in),
      .mem_we_in    (mem_we_in),
      .mux_in       (mux_in),
      .rd2_in       (rd2_in),
      .alu_in       (alu_in),
      .wa_in        (wa_in),
      .stall_out    (stall_out),
      .dmem         (dmem),
      .wb_valid     (wb_valid),
      .wb_we        (wb_we),
      .wb_wa        (wb_wa),
      .wb_data      (wb_data),
      .mem_err      (mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        bypass;
      logic        we;
      logic        mux;
      logic [15:0] rd2;
      logic [15:0] alu;
      logic [4:0]  wa;
      int          delay;
      logic [15:0] rdata;
      logic        exp_we;
      logic [15:0] exp_data;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [15:0] data;
      logic        err;
      logic        chk_data;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Writeback monitor: every wb_valid pulse must match the oldest expected entry
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("wb_unexpected", 64'(wb_valid), 64'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("wb_we", 64'(wb_we), 64'(e.we));
               check("wb_wa", 64'(wb_wa), 64'(e.wa));
               check("mem_err", 64'(mem_err), 64'(e.err));
               if (e.chk_data) check("wb_data", 64'(wb_data), 64'(e.data));
            end
         end
      end
   end

   task automatic drive(input vec_t v);
      in_valid      = 1'b1;
      mem_bypass_in = v.bypass;
      mem_we_in     = v.we;
      mux_in        = v.mux;
      rd2_in        = v.rd2;
      alu_in        = v.alu;
      wa_in         = v.wa;
   endtask

   // Runs one instruction from a negedge; returns at the negedge after its writeback edge,
   // leaving in_valid asserted so the caller can chain the next instruction back-to-back.
   task automatic run_vec(input vec_t v);
      exp_t e;
      drive(v);
      e.we = v.exp_we; e.wa = v.wa; e.data = v.exp_data; e.err = 1'b0; e.chk_data = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      if (!v.bypass) begin
         for (int c = 0; c < v.delay; c++) begin
            check("dmem_busy", 64'({stall_out, dmem.req, dmem.we, dmem.addr, dmem.wdata}),
                  64'({1'b1, 1'b1, v.we, v.alu, v.rd2}));
            if (c == v.delay - 1) begin
               dmem.ack   = 1'b1;
               dmem.rdata = v.rdata;
            end
            @(negedge clk);
            dmem.ack   = 1'b0;
            dmem.rdata = 16'h0BAD;
         end
         check("dmem_release", 64'({stall_out, dmem.req}), 64'(0));
      end
   endtask

   initial begin
      //          byp   we    mux   rd2       alu       wa     dly rdata     exp_we data
      vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 5'd5,  0, 16'h0000, 1'b1, 16'h1234};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h1111, 16'h00FF, 5'd0,  0, 16'h0000, 1'b0, 16'h00FF};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h2222, 16'h7777, 5'd9,  0, 16'h9999, 1'b1, 16'h7777};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h3333, 16'h0040, 5'd3,  3, 16'hBEEF, 1'b1, 16'hBEEF};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 16'hA5A5, 16'h0010, 5'd7,  1, 16'h4444, 1'b0, 16'h0000};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h5555, 16'h1357, 5'd4,  2, 16'hDEAD, 1'b1, 16'h1357};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h6666, 16'h0002, 5'd0,  1, 16'hCAFE, 1'b0, 16'hCAFE};
      vecs[7] = '{1'b0, 1'b0, 1'b1, 16'h7777, 16'hFFFE, 5'd31, 4, 16'h0123, 1'b1, 16'h0123};

      rst           = 1'b1;
      in_valid      = 1'b1;
      mem_bypass_in = 1'b1;
      mem_we_in     = 1'b0;
      mux_in        = 1'b0;
      rd2_in        = 16'h0;
      alu_in        = 16'h5555;
      wa_in         = 5'd5;
      dmem.ack      = 1'b0;
      dmem.rdata    = 16'h0;
      repeat (2) @(negedge clk);
      check("reset_outputs",
            64'({stall_out, dmem.req, dmem.we, dmem.addr, dmem.wdata,
                 wb_valid, wb_we, wb_wa, wb_data, mem_err}), 64'(0));
      rst      = 1'b0;
      in_valid = 1'b0;
      mon_en   = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);

      // Stray ack while idle must not retire anything or start a request
      dmem.ack   = 1'b1;
      dmem.rdata = 16'hFACE;
      @(negedge clk);
      dmem.ack = 1'b0;
      check("idle_ack", 64'({wb_valid, dmem.req, stall_out}), 64'(0));

      // Reset in the middle of an access: dropped, no writeback
      drive('{1'b0, 1'b0, 1'b1, 16'h0, 16'h0020, 5'd6, 0, 16'h0, 1'b0, 16'h0});
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_reset_req", 64'({dmem.req, stall_out}), 64'(2'b11));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset", 64'({dmem.req, stall_out, wb_valid}), 64'(0));
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset_idle", 64'({dmem.req, stall_out, wb_valid}), 64'(0));
      end
      run_vec('{1'b1, 1'b0, 1'b0, 16'h0, 16'h4321, 5'd2, 0, 16'h0, 1'b1, 16'h4321});
      in_valid = 1'b0;
      @(negedge clk);

`ifdef MEM_TIMEOUT_EN
      begin
         exp_t e;
         int   cyc;
         drive('{1'b0, 1'b0, 1'b1, 16'h0, 16'h0080, 5'd8, 0, 16'h0, 1'b0, 16'h0});
         e.we = 1'b0; e.wa = 5'd8; e.data = 16'h0; e.err = 1'b1; e.chk_data = 1'b0;
         sb.push_back(e);
         @(negedge clk);
         in_valid = 1'b0;
         cyc = 0;
         while (dmem.req === 1'b1 && cyc < 20) begin
            cyc++;
            @(negedge clk);
         end
         check("timeout_req_cycles", 64'(cyc), 64'(4));
         check("timeout_release", 64'({stall_out, wb_valid, mem_err}), 64'(3'b011));
         @(negedge clk);
         check("timeout_err_pulse", 64'({wb_valid, mem_err}), 64'(0));
      end
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
